// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU single-port RAM arbiter.
package ram_arbiter_pkg;

  // Requester identity; LSU is the reset value of the last-grant tracker
  typedef enum logic {
    ARB_IFU = 1'b0,
    ARB_LSU = 1'b1
  } arb_port_e;

  // Implicit response pipeline state: RESP means a response returns this cycle
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  // Default number of blocked IFU cycles before fixed-priority mode forces an IFU grant
  localparam int unsigned ARB_MAX_WAIT = 8;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arb_grant.sv
// Combinational grant decision for the two RAM requesters.
module ram_arb_grant
  import ram_arbiter_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT,
  parameter int unsigned CW       = 4
) (
  input  logic          m0_valid_i,
  input  logic          m1_valid_i,
  input  arb_port_e     last_grant_i,
  input  logic [CW-1:0] starve_cnt_i,
  output logic          gnt0_o,
  output logic          gnt1_o
);

  // Pick at most one requester; conflicts resolve by round-robin or LSU priority with starvation escape
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (m0_valid_i && m1_valid_i) begin
      if (RR_EN) begin
        if (last_grant_i == ARB_LSU) begin
          gnt0_o = 1'b1;
        end else begin
          gnt1_o = 1'b1;
        end
      end else begin
        if (starve_cnt_i == CW'(MAX_WAIT)) begin
          gnt0_o = 1'b1;
        end else begin
          gnt1_o = 1'b1;
        end
      end
    end else if (m0_valid_i) begin
      gnt0_o = 1'b1;
    end else if (m1_valid_i) begin
      gnt1_o = 1'b1;
    end else begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
    end
  end

endmodule : ram_arb_grant

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0) and load/store (port 1).
// One access issues per cycle; read data comes back on the owning port one cycle later.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MW       = 4,
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_rsp_vld,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [MW-1:0] m1_wem,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rsp_vld,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic          gnt0_s;
  logic          gnt1_s;
  logic          m0_fire_s;
  logic          m1_fire_s;
  logic          fire_s;

  arb_state_e    state_q,      state_d;
  arb_port_e     last_grant_q, last_grant_d;
  arb_port_e     pend_owner_q, pend_owner_d;
  logic          pend_wr_q,    pend_wr_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [DW-1:0] din_q,        din_d;

  ram_arb_grant #(
    .RR_EN    (RR_EN),
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_grant (
    .m0_valid_i   (m0_valid),
    .m1_valid_i   (m1_valid),
    .last_grant_i (last_grant_q),
    .starve_cnt_i (starve_cnt_q),
    .gnt0_o       (gnt0_s),
    .gnt1_o       (gnt1_s)
  );

  // Qualify the grant with reset so nothing can issue while rst is held
  always_comb begin
    m0_ready = gnt0_s & ~rst;
    m1_ready = gnt1_s & ~rst;
  end

  assign m0_fire_s = m0_valid & m0_ready;
  assign m1_fire_s = m1_valid & m1_ready;
  assign fire_s    = m0_fire_s | m1_fire_s;

  // Steer the granted request onto the RAM pins; address and data hold when idle
  always_comb begin
    ram_cs  = fire_s;
    ram_we  = m1_fire_s & m1_we;
    ram_wem = {MW{1'b0}};
    ram_addr = addr_q;
    ram_din  = din_q;
    if (m0_fire_s) begin
      ram_addr = m0_addr;
    end else if (m1_fire_s) begin
      ram_addr = m1_addr;
      ram_wem  = m1_wem;
      ram_din  = m1_wdata;
    end else begin
      ram_addr = addr_q;
    end
  end

  // Route the RAM output to whichever port issued last cycle; writes ack with zero data
  always_comb begin
    m0_rsp_vld = 1'b0;
    m1_rsp_vld = 1'b0;
    m0_rdata   = {DW{1'b0}};
    m1_rdata   = {DW{1'b0}};
    if (state_q == ST_RESP) begin
      if (pend_owner_q == ARB_IFU) begin
        m0_rsp_vld = 1'b1;
        m0_rdata   = pend_wr_q ? {DW{1'b0}} : ram_dout;
      end else begin
        m1_rsp_vld = 1'b1;
        m1_rdata   = pend_wr_q ? {DW{1'b0}} : ram_dout;
      end
    end else begin
      m0_rsp_vld = 1'b0;
      m1_rsp_vld = 1'b0;
    end
  end

  // Next-state: response pipeline, fairness tracking and held RAM address/data
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pend_owner_d = pend_owner_q;
    pend_wr_d    = pend_wr_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = ram_addr;
    din_d        = ram_din;

    case (state_q)
      ST_IDLE: state_d = fire_s ? ST_RESP : ST_IDLE;
      ST_RESP: state_d = fire_s ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fire_s) begin
      last_grant_d = m0_fire_s ? ARB_IFU : ARB_LSU;
      pend_owner_d = m0_fire_s ? ARB_IFU : ARB_LSU;
      pend_wr_d    = m1_fire_s & m1_we;
    end else begin
      last_grant_d = last_grant_q;
    end

    if (m0_fire_s) begin
      starve_cnt_d = {CW{1'b0}};
    end else if (m0_valid && (starve_cnt_q != CW'(MAX_WAIT))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ARB_LSU;
      pend_owner_q <= ARB_IFU;
      pend_wr_q    <= 1'b0;
      starve_cnt_q <= {CW{1'b0}};
      addr_q       <= {AW{1'b0}};
      din_q        <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pend_owner_q <= pend_owner_d;
      pend_wr_q    <= pend_wr_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
    end
  end

endmodule : ram_arbiter
